// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: access-size encoding,
// FSM state type and address helpers used by the top and the lane aligner.
package lsu_pkg;

  localparam logic [1:0] FMT_BYTE = 2'd0;
  localparam logic [1:0] FMT_HALF = 2'd1;
  localparam logic [1:0] FMT_WORD = 2'd2;
  localparam logic [1:0] FMT_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Byte offset inside the word after dropping the bits below the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] fmt, input logic [1:0] lo);
    case (fmt)
      FMT_BYTE: return lo;
      FMT_HALF: return {lo[1], 1'b0};
      default:  return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] fmt, input logic [1:0] lo);
    return ((fmt == FMT_HALF) && lo[0]) || ((fmt == FMT_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data replication and strobes,
// plus load byte/half extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  fmt,
  input  logic        we,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lo;
  logic [31:0] shifted;

  always_comb begin
    lo          = align_lo(fmt, addr_lo);
    shifted     = rdata >> {lo, 3'b000};
    wdata_lanes = wdata;
    wstrb       = 4'b1111;
    rdata_ext   = rdata;
    case (fmt)
      FMT_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        wstrb       = 4'b0001 << lo;
        rdata_ext   = is_unsigned ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      FMT_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        wstrb       = lo[1] ? 4'b1100 : 4'b0011;
        rdata_ext   = is_unsigned ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    if (!we) wstrb = 4'b0000;
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master between a core request port and a word memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_format,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  import lsu_pkg::*;

  // state | meaning
  // IDLE  | req_ready high, waiting for req_valid
  // REQ   | mem_req held with stable mem_* until mem_gnt
  // WAIT  | waiting for mem_rvalid
  // RESP  | resp_valid pulse, back to IDLE

  lsu_state_e            state_q, state_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [1:0]            fmt_q, fmt_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  in_idle;
  logic                  illegal;
  logic [1:0]            la_addr;
  logic [1:0]            la_fmt;
  logic [DATA_WIDTH-1:0] la_wdata;
  logic [DATA_WIDTH-1:0] la_rdata;
  logic [3:0]            la_wstrb;

  assign in_idle = (state_q == IDLE);

  // The aligner sees the live request while idle and the latched one afterwards.
  assign la_addr = in_idle ? req_addr[1:0] : addr_lo_q;
  assign la_fmt  = in_idle ? req_format    : fmt_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign illegal = (req_format == FMT_ILL) || is_misaligned(req_format, req_addr[1:0]);
`else
  assign illegal = (req_format == FMT_ILL);
`endif

  lsu_lane_align u_lane_align (
    .addr_lo     (la_addr),
    .fmt         (la_fmt),
    .we          (req_we),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .wdata_lanes (la_wdata),
    .wstrb       (la_wstrb),
    .rdata_ext   (la_rdata)
  );

  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    fmt_d        = fmt_q;
    uns_d        = uns_q;
    we_d         = we_q;
    req_ready_d  = req_ready_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d   = req_addr[1:0];
          fmt_d       = req_format;
          uns_d       = req_unsigned;
          we_d        = req_we;
          req_ready_d = 1'b0;
          if (illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = la_wdata;
            mem_wstrb_d = la_wstrb;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : la_rdata;
        end
      end
      RESP: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_lo_q    <= 2'b00;
      fmt_q        <= FMT_BYTE;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      fmt_q        <= fmt_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed cases plus randomized traffic
// against a byte-level reference model, with a randomized memory responder.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_format;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_format   (req_format),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic        we;
    logic [3:0]  wstrb;
    int          gdly;
    int          rdly;
    bit          kill;
  } mtx_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          lat;
  } rsp_t;

  mtx_t memq[$];
  rsp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   abort = 0;
  bit   wait_reached = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-granular view of the access, independent of RTL structure.
  task automatic issue(input logic we, input logic [1:0] fmt, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mword, input int gdly, input int rdly,
                       input bit lat, input bit kill);
    mtx_t        m;
    rsp_t        r;
    int          size;
    int          lane;
    int          n;
    bit          ill;
    logic [31:0] mask;
    logic [31:0] v;
    size = 1 << fmt;
    ill  = (fmt == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!ill && (int'(addr[1:0]) % size) != 0) ill = 1;
`endif
    m.addr = addr & 32'hFFFF_FFFC;
    m.we = we; m.mword = mword; m.gdly = gdly; m.rdly = rdly; m.kill = kill;
    m.wstrb = 4'b0000; m.wdata = 32'd0;
    r.rdata = 32'd0; r.err = ill; r.lat = lat; r.acc = 0;
    if (!ill) begin
      lane = (int'(addr[1:0]) / size) * size;
      if (we) m.wstrb = 4'(((1 << size) - 1) << lane);
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      v = (mword >> (8*lane)) & mask;
      if (!uns && size < 4 && v[8*size-1]) v = v | ~mask;
      r.rdata = we ? 32'd0 : v;
    end
    req_valid = 1'b1; req_we = we; req_format = fmt; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=0 expected=1");
      abort = 1;
      req_valid = 1'b0;
      return;
    end
    r.acc = cyc;
    if (!kill) expq.push_back(r);
    if (!ill) memq.push_back(m);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_format = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (!rst && resp_valid) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=resp_valid expected=none rdata=0x%08h", resp_rdata);
      end else begin
        r = expq.pop_front();
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_err", 32'(resp_err), 32'(r.err));
        if (r.lat) chk("latency", 32'(cyc - r.acc), 32'd3);
      end
    end
  end

  // Memory responder
  initial begin
    mtx_t e;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      if (rst) begin
        mem_rvalid = 1'b0;
        continue;
      end
      if (!mem_req) begin
        mem_rvalid = ($urandom_range(0, 7) == 0);
        mem_rdata  = $urandom;
        continue;
      end
      if (memq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_req actual=1 expected=0 addr=0x%08h", mem_addr);
        mem_rvalid = 1'b0;
        continue;
      end
      e = memq.pop_front();
      for (int c = 0; c <= e.gdly; c++) begin
        if (c > 0) @(negedge clk);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        mem_rvalid = (c < e.gdly) ? 1'($urandom) : 1'b0;
        mem_rdata  = $urandom;
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      if (e.kill) begin
        wait_reached = 1;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = e.mword;
        @(negedge clk);
        mem_rvalid = 1'b0;
        wait_reached = 0;
        continue;
      end
      for (int c = 0; c < e.rdly; c++) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = e.mword;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_format = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // we, fmt, uns, addr, wdata, mword, gdly, rdly, lat, kill
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0, 32'h80AA_BBCC, 0, 0, 1, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'd0, 32'h8001_1234, 0, 0, 1, 0);
    issue(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h0000_00AB, 32'h5555_5555, 0, 1, 0, 0);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 3, 0, 0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'd0, 32'hCAFE_F00D, 1, 1, 0, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_3003, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0);
    issue(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'd0, 32'h0, 0, 0, 0, 0);
    issue(1'b1, 2'd3, 1'b1, 32'h0000_4001, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_5000, 32'd0, 32'h1234_F00F, 0, 2, 0, 0);

    for (int i = 0; i < 150 && !abort; i++)
      issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);

    if (!abort) begin
      issue(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0, 32'h1357_9BDF, 0, 0, 0, 1);
      n = 0;
      while (!wait_reached && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!wait_reached) begin
        checks++; errors++;
        $display("FAIL wait_state_timeout actual=0 expected=1");
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req_ready", 32'(req_ready), 32'd1);
      chk("async_rst_mem_req", 32'(mem_req), 32'd0);
      chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      for (int k = 0; k < 5; k++) begin
        chk("late_rvalid_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      issue(1'b0, 2'd0, 1'b1, 32'h0000_7002, 32'd0, 32'h00C3_0000, 0, 0, 1, 0);
    end

    n = 0;
    while ((expq.size() != 0 || memq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0 || memq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d/%0d expected=0/0", expq.size(), memq.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
